// File: rtl/iq_upsampler_pkg.sv
// Shared definitions for the IQ upsampler: mode encodings and lane sizing helper.
package iq_upsampler_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_LINEAR = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Width of the interpolation product: (WIDTH+1)-bit difference times a phase index.
    function automatic int unsigned lane_prod_width(input int unsigned width,
                                                    input int unsigned max_ratio_log2);
        return width + 1 + max_ratio_log2;
    endfunction

endpackage

// File: rtl/iq_upsampler_lane.sv
// One lane of the upsampler: holds cur/prev samples and produces the registered
// zero-stuff / hold / linear output for the phase supplied by the top level.
module iq_upsampler_lane
    import iq_upsampler_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned MAX_RATIO_LOG2 = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_load,
    input  logic [WIDTH-1:0]                        i_sample,
    input  logic [1:0]                              i_mode,
    input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0]     i_ratio,
    input  logic [MAX_RATIO_LOG2-1:0]               i_k,
    input  logic                                    i_sat,
    input  logic                                    i_en,
    output logic [WIDTH-1:0]                        o_data
);

    localparam int unsigned PW = lane_prod_width(WIDTH, MAX_RATIO_LOG2);

    logic [WIDTH-1:0]        r_cur;
    logic [WIDTH-1:0]        r_prev;
    logic [WIDTH-1:0]        r_out;

    logic [WIDTH-1:0]        w_cur_d;
    logic [WIDTH-1:0]        w_prev_d;
    logic signed [WIDTH:0]   w_diff;
    logic signed [PW-1:0]    w_prod;
    logic [WIDTH-1:0]        w_lin;
    logic [WIDTH-1:0]        w_res;

    // The output register sees the post-load samples so k=0 appears one cycle after in_val.
    assign w_cur_d  = i_load ? i_sample : r_cur;
    assign w_prev_d = i_load ? r_cur : r_prev;

    assign w_diff = $signed({w_cur_d[WIDTH-1], w_cur_d}) - $signed({w_prev_d[WIDTH-1], w_prev_d});
    assign w_prod = PW'(w_diff) * $signed({{(PW-MAX_RATIO_LOG2){1'b0}}, i_k});

    // The interpolated point lies between prev and cur, so modular WIDTH-bit addition is exact.
    assign w_lin = WIDTH'(w_prod >>> i_ratio) + w_prev_d;

    // Select the per-mode output; linear falls back to cur when R=1 or when late.
    always_comb begin
        w_res = w_cur_d;
        case (mode_e'(i_mode))
            MODE_ZERO:   w_res = (i_k == '0) ? w_cur_d : '0;
            MODE_LINEAR: begin
                if (!i_sat && (i_ratio != '0)) begin
                    w_res = w_lin;
                end
            end
            default:     w_res = w_cur_d;
        endcase
    end

    // Sample history and registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= '0;
            r_prev <= '0;
            r_out  <= '0;
        end else begin
            r_cur  <= w_cur_d;
            r_prev <= w_prev_d;
            r_out  <= i_en ? w_res : '0;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/iq_upsampler.sv
// Multi-lane IQ upsampler by 2^ratio_log2 with zero-stuff, hold and linear modes.
// Owns the shared phase counter, latched mode/ratio and the sticky flags.
module iq_upsampler
    import iq_upsampler_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned MAX_RATIO_LOG2 = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0]     ratio_log2,
    input  logic [1:0]                              mode,
    input  logic [CHANNELS*WIDTH-1:0]               in_data,
    input  logic                                    in_val,
    input  logic                                    clear_flags,
    output logic [CHANNELS*WIDTH-1:0]               out_data,
    output logic                                    out_val,
    output logic [MAX_RATIO_LOG2-1:0]               out_phase,
    output logic                                    overrun,
    output logic                                    underrun
);

    localparam int unsigned RW  = $clog2(MAX_RATIO_LOG2 + 1);
    localparam int unsigned PHW = MAX_RATIO_LOG2;

    logic [PHW-1:0] r_phase;
    logic [RW-1:0]  r_ratio;
    logic [1:0]     r_mode;
    logic           r_late;
    logic           r_out_val;
    logic           r_overrun;
    logic           r_underrun;

    logic [PHW-1:0] w_last_phase;
    logic           w_last;
    logic [RW-1:0]  w_ratio_in;
    logic [1:0]     w_mode_in;
    logic [PHW-1:0] w_phase_d;
    logic [RW-1:0]  w_ratio_d;
    logic [1:0]     w_mode_d;
    logic           w_late_d;
    logic           w_run_d;
    logic           w_ov_set;
    logic           w_un_set;

    // R-1 as a mask: shifting all-ones left by ratio leaves the low ratio bits clear.
    assign w_last_phase = ~({PHW{1'b1}} << r_ratio);
    assign w_last       = (r_phase == w_last_phase);

    assign w_ratio_in = (ratio_log2 > RW'(MAX_RATIO_LOG2)) ? RW'(MAX_RATIO_LOG2) : ratio_log2;
    assign w_mode_in  = (mode == MODE_RSVD) ? MODE_HOLD : mode;

    // Mode and ratio only change on in_val, so a period is never reshaped midway.
    assign w_mode_d  = in_val ? w_mode_in : r_mode;
    assign w_ratio_d = in_val ? w_ratio_in : r_ratio;
    assign w_phase_d = (in_val || w_last) ? '0 : r_phase + PHW'(1);
    assign w_run_d   = r_out_val | in_val;

    // Late: the period wrapped without a new sample. Linear then holds at cur
    // (interpolation saturated at the end of the segment) until the next in_val.
    assign w_late_d = in_val ? 1'b0 : ((r_out_val && w_last) ? 1'b1 : r_late);

    assign w_ov_set = in_val & r_out_val & ~w_last;
    assign w_un_set = r_out_val & w_last & ~in_val;

    // Shared control state and sticky flags; a set in the clear cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_ratio    <= '0;
            r_mode     <= MODE_HOLD;
            r_late     <= 1'b0;
            r_out_val  <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_phase    <= w_phase_d;
            r_ratio    <= w_ratio_d;
            r_mode     <= w_mode_d;
            r_late     <= w_late_d;
            r_out_val  <= w_run_d;
            r_overrun  <= w_ov_set | (r_overrun & ~clear_flags);
            r_underrun <= w_un_set | (r_underrun & ~clear_flags);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        iq_upsampler_lane #(
            .WIDTH          (WIDTH),
            .MAX_RATIO_LOG2 (MAX_RATIO_LOG2)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_load   (in_val),
            .i_sample (in_data[g*WIDTH +: WIDTH]),
            .i_mode   (w_mode_d),
            .i_ratio  (w_ratio_d),
            .i_k      (w_phase_d),
            .i_sat    (w_late_d),
            .i_en     (w_run_d),
            .o_data   (out_data[g*WIDTH +: WIDTH])
        );
    end

    assign out_val   = r_out_val;
    assign out_phase = r_phase;
    assign overrun   = r_overrun;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_iq_upsampler.sv
// Scoreboard bench for iq_upsampler (WIDTH=16, CHANNELS=2, MAX_RATIO_LOG2=3).
module tb_iq_upsampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ratio_log2;
    logic [1:0]  mode;
    logic [31:0] in_data;
    logic        in_val;
    logic        clear_flags;
    logic [31:0] out_data;
    logic        out_val;
    logic [2:0]  out_phase;
    logic        overrun;
    logic        underrun;

    iq_upsampler #(
        .WIDTH          (16),
        .CHANNELS       (2),
        .MAX_RATIO_LOG2 (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ratio_log2  (ratio_log2),
        .mode        (mode),
        .in_data     (in_data),
        .in_val      (in_val),
        .clear_flags (clear_flags),
        .out_data    (out_data),
        .out_val     (out_val),
        .out_phase   (out_phase),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        val;
        logic [2:0]  ph;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ov;
        logic        un;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] hist[$];
    bit          rec = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    int m_cur[2];
    int m_prev[2];
    int m_mode, m_ratio, m_phase;
    bit m_late, m_run, m_ov, m_un;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int s16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    function automatic int exp_lane(input int l);
        int r;
        if (!m_run) return 0;
        r = 1 << m_ratio;
        case (m_mode)
            0:       return (m_phase == 0) ? m_cur[l] : 0;
            2:       return (m_late || r == 1) ? m_cur[l]
                            : m_prev[l] + fdiv((m_cur[l] - m_prev[l]) * m_phase, r);
            default: return m_cur[l];
        endcase
    endfunction

    task automatic step(input bit r, input bit v, input int d0, input int d1,
                        input int md, input int rt, input bit clr);
        exp_t e;
        bit   last, ov_set, un_set;
        int   t0, t1;
        rst         = r;
        in_val      = v;
        in_data     = {d1[15:0], d0[15:0]};
        mode        = md[1:0];
        ratio_log2  = rt[1:0];
        clear_flags = clr;
        if (r) begin
            m_cur   = '{0, 0};
            m_prev  = '{0, 0};
            m_mode  = 1;
            m_ratio = 0;
            m_phase = 0;
            m_late  = 0;
            m_run   = 0;
            m_ov    = 0;
            m_un    = 0;
        end else begin
            last   = (m_phase == (1 << m_ratio) - 1);
            ov_set = v && m_run && !last;
            un_set = m_run && last && !v;
            if (v) begin
                m_prev  = m_cur;
                m_cur   = '{s16(d0), s16(d1)};
                m_mode  = (md == 3) ? 1 : md;
                m_ratio = (rt > 3) ? 3 : rt;
                m_phase = 0;
                m_late  = 0;
            end else if (last) begin
                m_phase = 0;
                if (m_run) m_late = 1;
            end else begin
                m_phase++;
            end
            m_run = m_run || v;
            m_ov  = ov_set || (m_ov && !clr);
            m_un  = un_set || (m_un && !clr);
        end
        t0 = exp_lane(0);
        t1 = exp_lane(1);
        e.val = m_run;
        e.ph  = m_phase[2:0];
        e.d0  = t0[15:0];
        e.d1  = t1[15:0];
        e.ov  = m_ov;
        e.un  = m_un;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_val", 32'(out_val), 32'(e.val));
        check("out_phase", 32'(out_phase), 32'(e.ph));
        check("lane0", 32'(out_data[15:0]), 32'(e.d0));
        check("lane1", 32'(out_data[31:16]), 32'(e.d1));
        check("overrun", 32'(overrun), 32'(e.ov));
        check("underrun", 32'(underrun), 32'(e.un));
        if (rec) hist.push_back(out_data[15:0]);
    endtask

    // Idle cycles drive random data, mode and ratio, which must all be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, int'($urandom), int'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 0);
        end
    endtask

    task automatic period(input int d0, input int d1, input int md, input int rt, input int len);
        step(0, 1, d0, d1, md, rt, 0);
        idle(len - 1);
    endtask

    int          exp_lin[8] = '{0, 100, 200, 300, 400, 200, 0, -200};
    logic [15:0] tmp16;

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_val", 32'(out_val), 32'd0);
        check("rst_data", out_data, 32'd0);

        // Hold, R=8
        rec = 1'b1;
        period(100, -100, 1, 3, 8);
        period(200, -200, 1, 3, 8);
        rec = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tmp16 = (i < 8) ? 16'd100 : 16'd200;
            check("hold_seq", 32'(hist[i]), 32'(tmp16));
        end
        check("hold_ov", 32'(overrun), 32'd0);
        check("hold_un", 32'(underrun), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Zero-stuff, R=4
        for (int i = 0; i < 3; i++) period(1000, -7, 0, 2, 4);
        step(1, 0, 0, 0, 0, 0, 0);

        // Linear, R=4
        hist.delete();
        period(0, 0, 2, 2, 4);
        rec = 1'b1;
        period(400, -1, 2, 2, 4);
        period(-400, 1, 2, 2, 4);
        rec = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tmp16 = exp_lin[i][15:0];
            check("lin_seq", 32'(hist[i]), 32'(tmp16));
        end
        step(1, 0, 0, 0, 0, 0, 0);

        // Linear, R=8, full-scale swings
        period(32767, -32768, 2, 3, 8);
        period(-32768, 32767, 2, 3, 8);
        period(32767, -32768, 2, 3, 8);
        step(1, 0, 0, 0, 0, 0, 0);

        // Flags, R=4: early in_val with a simultaneous clear, then a withheld input
        period(5, 5, 1, 2, 4);
        step(0, 1, 6, 6, 1, 2, 0);
        idle(1);
        step(0, 1, 7, 7, 1, 2, 1);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_restart", 32'(out_phase), 32'd0);
        idle(6);
        check("unr_set", 32'(underrun), 32'd1);
        step(0, 0, 0, 0, 1, 2, 1);
        check("ovr_clr", 32'(overrun), 32'd0);
        check("unr_clr", 32'(underrun), 32'd0);
        period(8, 8, 1, 2, 4);
        step(1, 0, 0, 0, 0, 0, 0);

        // R=1 hold then linear, plus a missing input
        for (int i = 0; i < 4; i++) step(0, 1, 10 * i, -i, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 300 - 50 * i, 3 * i, 2, 0, 0);
        idle(1);
        check("r1_unr", 32'(underrun), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);

        // Reserved mode acts as hold
        period(77, -77, 3, 1, 2);
        period(-5, 5, 3, 1, 2);

        // Reset mid-period, with in_val in the reset cycle
        period(10, 20, 0, 2, 2);
        step(1, 1, 99, 99, 2, 2, 0);
        check("midrst_val", 32'(out_val), 32'd0);
        check("midrst_data", out_data, 32'd0);
        idle(3);
        check("midrst_hold", 32'(out_val), 32'd0);
        step(0, 1, 11, 12, 1, 1, 0);
        check("midrst_rise", 32'(out_val), 32'd1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom), int'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
